// File: rtl/riscv_pkg.sv
// Shared encodings for the MEM-stage load/store unit: RV32I width codes,
// LSU FSM states and exception cause codes.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } lsu_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE        = 2'b00,
    CAUSE_LD_MISALIGN = 2'b01,
    CAUSE_ST_MISALIGN = 2'b10,
    CAUSE_ILLEGAL     = 2'b11
  } lsu_cause_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables / lane replication / legality
// for the op being accepted, and lane extraction / extension for returning loads.
module lsu_align
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      ex_funct3,
  input  logic [1:0]      ex_addr_lo,
  input  logic            is_store,
  input  logic [XLEN-1:0] wdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] lane_wdata,
  output logic            legal,
  output logic            misaligned,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] load_data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    be         = '0;
    lane_wdata = wdata;
    case (ex_funct3)
      F3_B: begin
        legal      = 1'b1;
        be         = 4'b0001 << ex_addr_lo;
        lane_wdata = {4{wdata[7:0]}};
      end
      F3_H: begin
        legal      = 1'b1;
        misaligned = ex_addr_lo[0];
        be         = ex_addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata[15:0]}};
      end
      F3_W: begin
        legal      = 1'b1;
        misaligned = |ex_addr_lo;
        be         = 4'b1111;
      end
      // Unsigned widths exist only for loads
      F3_BU: begin
        legal = !is_store;
        be    = 4'b0001 << ex_addr_lo;
      end
      F3_HU: begin
        legal      = !is_store;
        misaligned = ex_addr_lo[0];
        be         = ex_addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted   = rdata >> {ld_addr_lo, 3'b000};
    load_data = shifted;
    case (ld_funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data = {24'h000000, shifted[7:0]};
      F3_HU:   load_data = {16'h0000, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one outstanding req/gnt/rvalid access to data
// memory, exception reporting on refused ops, extended load writeback.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [2:0]        ex_funct3,
  input  logic [XLEN-1:0]   ex_addr,
  input  logic [XLEN-1:0]   ex_wdata,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              flush,
  output logic              lsu_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              lsu_exc,
  output logic [1:0]        exc_cause,
  output logic [XLEN-1:0]   exc_addr
);

  lsu_state_t        state_q, state_d;
  logic              kill_q, kill_d;
  logic [2:0]        funct3_q;
  logic [1:0]        addr_lo_q;
  logic [REG_AW-1:0] rd_q;

  logic [3:0]        be;
  logic [XLEN-1:0]   lane_wdata;
  logic [XLEN-1:0]   load_data;
  logic              legal, misaligned;
  logic              accept, fault, wb_fire;
  lsu_cause_t        cause;

  lsu_align #(.XLEN(XLEN)) u_align (
    .ex_funct3  (ex_funct3),
    .ex_addr_lo (ex_addr[1:0]),
    .is_store   (ex_is_store),
    .wdata      (ex_wdata),
    .be         (be),
    .lane_wdata (lane_wdata),
    .legal      (legal),
    .misaligned (misaligned),
    .ld_funct3  (funct3_q),
    .ld_addr_lo (addr_lo_q),
    .rdata      (dmem_rdata),
    .load_data  (load_data)
  );

  always_comb begin
    accept = (state_q == IDLE) && ex_valid && (ex_is_load || ex_is_store) && !flush;
    fault  = !legal || misaligned;
    if (!legal)           cause = CAUSE_ILLEGAL;
    else if (ex_is_store) cause = CAUSE_ST_MISALIGN;
    else                  cause = CAUSE_LD_MISALIGN;
    // A flush coinciding with rvalid also suppresses the writeback
    wb_fire = (state_q == WAIT) && dmem_rvalid && !kill_q && !flush;
  end

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    case (state_q)
      IDLE: if (accept && !fault) state_d = REQ;
      REQ: begin
        if (dmem_gnt) begin
          if (dmem_we) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT;
            kill_d  = flush;
          end
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (flush) kill_d = 1'b1;
        if (dmem_rvalid) begin
          state_d = IDLE;
          kill_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      kill_q     <= 1'b0;
      funct3_q   <= '0;
      addr_lo_q  <= '0;
      rd_q       <= '0;
      lsu_stall  <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      lsu_exc    <= 1'b0;
      exc_cause  <= '0;
      exc_addr   <= '0;
    end else begin
      state_q   <= state_d;
      kill_q    <= kill_d;
      lsu_stall <= (state_d != IDLE);
      dmem_req  <= (state_d == REQ);
      wb_valid  <= wb_fire;
      lsu_exc   <= accept && fault;
      if (accept && fault) begin
        exc_cause <= cause;
        exc_addr  <= ex_addr;
      end
      if (accept && !fault) begin
        dmem_we    <= ex_is_store;
        dmem_addr  <= {ex_addr[XLEN-1:2], 2'b00};
        dmem_be    <= be;
        dmem_wdata <= ex_is_store ? lane_wdata : '0;
        funct3_q   <= ex_funct3;
        addr_lo_q  <= ex_addr[1:0];
        rd_q       <= ex_rd;
      end
      if (wb_fire) begin
        wb_rd   <= rd_q;
        wb_data <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: inputs driven on the falling edge,
// outputs sampled on the falling edge after each rising edge.
module tb_load_store_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_is_load, ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        flush;
  logic        lsu_stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lsu_exc;
  logic [1:0]  exc_cause;
  logic [31:0] exc_addr;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .flush(flush), .lsu_stall(lsu_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .lsu_exc(lsu_exc), .exc_cause(exc_cause), .exc_addr(exc_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st;
    ex_funct3 = f3; ex_addr = addr; ex_wdata = wd; ex_rd = rd;
  endtask

  task automatic drop_op();
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
  endtask

  // Best-case load: accept, immediate gnt, immediate rvalid
  task automatic load_op(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [4:0] rd, input logic [31:0] word, input logic [31:0] exp);
    drive_op(1'b1, 1'b0, f3, addr, 32'h0, rd);
    tick(); drop_op();
    check($sformatf("%s.req", tag), {31'b0, dmem_req}, 32'd1);
    check($sformatf("%s.we", tag), {31'b0, dmem_we}, 32'd0);
    check($sformatf("%s.addr", tag), dmem_addr, {addr[31:2], 2'b00});
    check($sformatf("%s.stall1", tag), {31'b0, lsu_stall}, 32'd1);
    dmem_gnt = 1'b1;
    tick(); dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = word;
    check($sformatf("%s.stall2", tag), {31'b0, lsu_stall}, 32'd1);
    check($sformatf("%s.req_drop", tag), {31'b0, dmem_req}, 32'd0);
    tick(); dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    check($sformatf("%s.wbv", tag), {31'b0, wb_valid}, 32'd1);
    check($sformatf("%s.wbd", tag), wb_data, exp);
    check($sformatf("%s.wbrd", tag), {27'b0, wb_rd}, {27'b0, rd});
    check($sformatf("%s.stall3", tag), {31'b0, lsu_stall}, 32'd0);
    tick();
    check($sformatf("%s.wb_pulse", tag), {31'b0, wb_valid}, 32'd0);
  endtask

  task automatic store_op(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] exp_be, input logic [31:0] exp_wd);
    drive_op(1'b0, 1'b1, f3, addr, wd, 5'd0);
    tick(); drop_op();
    check($sformatf("%s.req", tag), {31'b0, dmem_req}, 32'd1);
    check($sformatf("%s.we", tag), {31'b0, dmem_we}, 32'd1);
    check($sformatf("%s.addr", tag), dmem_addr, {addr[31:2], 2'b00});
    check($sformatf("%s.be", tag), {28'b0, dmem_be}, {28'b0, exp_be});
    check($sformatf("%s.wdata", tag), dmem_wdata, exp_wd);
    dmem_gnt = 1'b1;
    tick(); dmem_gnt = 1'b0;
    check($sformatf("%s.req_drop", tag), {31'b0, dmem_req}, 32'd0);
    check($sformatf("%s.stall", tag), {31'b0, lsu_stall}, 32'd0);
  endtask

  task automatic fault_op(input string tag, input logic ld, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [1:0] exp_cause);
    drive_op(ld, !ld, f3, addr, 32'h0, 5'd1);
    tick(); drop_op();
    check($sformatf("%s.exc", tag), {31'b0, lsu_exc}, 32'd1);
    check($sformatf("%s.cause", tag), {30'b0, exc_cause}, {30'b0, exp_cause});
    check($sformatf("%s.eaddr", tag), exc_addr, addr);
    check($sformatf("%s.noreq", tag), {31'b0, dmem_req}, 32'd0);
    check($sformatf("%s.nostall", tag), {31'b0, lsu_stall}, 32'd0);
    tick();
    check($sformatf("%s.exc_pulse", tag), {31'b0, lsu_exc}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check($sformatf("%s.stall", tag), {31'b0, lsu_stall}, 32'd0);
    check($sformatf("%s.req", tag), {31'b0, dmem_req}, 32'd0);
    check($sformatf("%s.we", tag), {31'b0, dmem_we}, 32'd0);
    check($sformatf("%s.addr", tag), dmem_addr, 32'h0);
    check($sformatf("%s.be", tag), {28'b0, dmem_be}, 32'h0);
    check($sformatf("%s.wdata", tag), dmem_wdata, 32'h0);
    check($sformatf("%s.wbv", tag), {31'b0, wb_valid}, 32'd0);
    check($sformatf("%s.wbd", tag), wb_data, 32'h0);
    check($sformatf("%s.wbrd", tag), {27'b0, wb_rd}, 32'h0);
    check($sformatf("%s.exc", tag), {31'b0, lsu_exc}, 32'd0);
    check($sformatf("%s.cause", tag), {30'b0, exc_cause}, 32'h0);
    check($sformatf("%s.eaddr", tag), exc_addr, 32'h0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    ex_funct3 = 3'b000; ex_addr = 32'h0; ex_wdata = 32'h0; ex_rd = 5'd0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    load_op("lw",  F3_W,  32'h0000_0100, 5'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    load_op("lb",  F3_B,  32'h0000_0103, 5'd4, 32'h80FF_0000, 32'hFFFF_FF80);
    load_op("lbu", F3_BU, 32'h0000_0103, 5'd5, 32'h80FF_0000, 32'h0000_0080);
    load_op("lh",  F3_H,  32'h0000_0102, 5'd6, 32'h80FF_0000, 32'hFFFF_80FF);
    load_op("lhu", F3_HU, 32'h0000_0102, 5'd7, 32'h80FF_0000, 32'h0000_80FF);

    store_op("sb", F3_B, 32'h0000_0201, 32'h1234_56AB, 4'b0010, 32'hABAB_ABAB);
    store_op("sh", F3_H, 32'h0000_0202, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);
    store_op("sw", F3_W, 32'h0000_0204, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

    fault_op("lw_mis",  1'b1, F3_W,   32'h0000_0102, 2'b01);
    fault_op("ld_ill",  1'b1, 3'b011, 32'h0000_0100, 2'b11);
    fault_op("sh_mis",  1'b0, F3_H,   32'h0000_0203, 2'b10);
    fault_op("sbu_ill", 1'b0, F3_BU,  32'h0000_0200, 2'b11);

    // gnt withheld for three cycles
    drive_op(1'b1, 1'b0, F3_W, 32'h0000_0300, 32'h0, 5'd9);
    tick(); drop_op();
    for (int i = 0; i < 3; i++) begin
      check("hold.req", {31'b0, dmem_req}, 32'd1);
      check("hold.addr", dmem_addr, 32'h0000_0300);
      check("hold.stall", {31'b0, lsu_stall}, 32'd1);
      tick();
    end
    dmem_gnt = 1'b1;
    tick(); dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h1357_9BDF;
    tick(); dmem_rvalid = 1'b0;
    check("hold.wbv", {31'b0, wb_valid}, 32'd1);
    check("hold.wbd", wb_data, 32'h1357_9BDF);
    check("hold.wbrd", {27'b0, wb_rd}, 32'd9);
    tick();

    // flush in REQ cancels without access
    drive_op(1'b1, 1'b0, F3_W, 32'h0000_0400, 32'h0, 5'd10);
    tick(); drop_op();
    check("fl_req.req", {31'b0, dmem_req}, 32'd1);
    flush = 1'b1;
    tick(); flush = 1'b0;
    check("fl_req.req_drop", {31'b0, dmem_req}, 32'd0);
    check("fl_req.stall", {31'b0, lsu_stall}, 32'd0);
    tick();
    check("fl_req.nowb", {31'b0, wb_valid}, 32'd0);

    // flush together with ex_valid: no accept
    drive_op(1'b1, 1'b0, F3_W, 32'h0000_0500, 32'h0, 5'd11);
    flush = 1'b1;
    tick(); drop_op(); flush = 1'b0;
    check("fl_acc.req", {31'b0, dmem_req}, 32'd0);
    check("fl_acc.stall", {31'b0, lsu_stall}, 32'd0);

    // flush in WAIT suppresses writeback
    drive_op(1'b1, 1'b0, F3_W, 32'h0000_0600, 32'h0, 5'd12);
    tick(); drop_op();
    dmem_gnt = 1'b1;
    tick(); dmem_gnt = 1'b0; flush = 1'b1;
    tick(); flush = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h2468_ACE0;
    check("fl_wait.stall", {31'b0, lsu_stall}, 32'd1);
    tick(); dmem_rvalid = 1'b0;
    check("fl_wait.nowb", {31'b0, wb_valid}, 32'd0);
    check("fl_wait.idle", {31'b0, lsu_stall}, 32'd0);

    // reset while waiting on rvalid
    drive_op(1'b1, 1'b0, F3_W, 32'h0000_0700, 32'h0, 5'd13);
    tick(); drop_op();
    dmem_gnt = 1'b1;
    tick(); dmem_gnt = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0;
    check_all_zero("rst_wait");
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
    tick(); dmem_rvalid = 1'b0;
    check("late_rvalid.nowb", {31'b0, wb_valid}, 32'd0);
    load_op("lw_after", F3_W, 32'h0000_0800, 5'd14, 32'h0BAD_F00D, 32'h0BAD_F00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
